// File: rtl/hc148_key_event_capture_pkg.sv
// Shared types and constants for the HC148 key event capture block.
// Event layout is {press, code[2:0]}; the encoder idles at code 3'b111.
package hc148_key_event_capture_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned EVT_W  = CODE_W + 1;

    localparam logic [CODE_W-1:0] IDLE_CODE = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_t;

    typedef struct packed {
        logic              press;
        logic [CODE_W-1:0] code;
    } evt_t;

    function automatic evt_t mk_evt(input logic press, input logic [CODE_W-1:0] code);
        evt_t e;
        e.press = press;
        e.code  = code;
        return e;
    endfunction

endpackage

// File: rtl/hc148_key_event_capture_if.sv
// Valid/ready event stream between the capture block (master) and its consumer (slave).
interface hc148_key_event_capture_if;
    import hc148_key_event_capture_pkg::*;

    logic [CODE_W-1:0] evt_code;
    logic              evt_press;
    logic              evt_valid;
    logic              evt_ready;

    modport master (
        output evt_code,
        output evt_press,
        output evt_valid,
        input  evt_ready
    );

    modport slave (
        input  evt_code,
        input  evt_press,
        input  evt_valid,
        output evt_ready
    );

endinterface

// File: rtl/hc148_key_event_capture_evt_fifo.sv
// First-word fall-through event FIFO; a push while full (and not popping) is dropped.
module hc148_key_event_capture_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_drop,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the slot in the same cycle, so full+push+pop is not a drop.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/hc148_key_event_capture.sv
// HC148 encoder consumer: sync, debounce, press/release events into a FWFT FIFO.
// Optional auto-repeat while held is enabled by defining HC148_KEY_REPEAT_EN.
module hc148_key_event_capture
    import hc148_key_event_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_CYCLES   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    output logic                        o_ei,
    input  logic [CODE_W-1:0]           i_code_n,
    input  logic                        i_gs_n,
    hc148_key_event_capture_if.master   evt_if,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_overflow,
    input  logic                        i_ovf_clr
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    end

    logic [CODE_W-1:0] r_code_s1;
    logic [CODE_W-1:0] r_code_s2;
    logic              r_gsn_s1;
    logic              r_gsn_s2;
    logic              r_ei;
    logic              r_ovf;
    state_t            r_state;
    logic [DBW-1:0]    r_cnt;
    logic [CODE_W-1:0] r_cur;

    logic [CODE_W-1:0] w_key;
    logic              w_act;
    logic              w_same;
    logic              w_rep_hit;
    logic              w_push;
    evt_t              w_evt;
    evt_t              w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;

    assign w_key  = ~r_code_s2;
    assign w_act  = ~r_gsn_s2;
    assign w_same = w_act & (w_key == r_cur);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code_s1 <= IDLE_CODE;
            r_code_s2 <= IDLE_CODE;
            r_gsn_s1  <= 1'b1;
            r_gsn_s2  <= 1'b1;
            r_ei      <= 1'b1;
        end else begin
            r_code_s1 <= i_code_n;
            r_code_s2 <= r_code_s1;
            r_gsn_s1  <= i_gs_n;
            r_gsn_s2  <= r_gsn_s1;
            r_ei      <= ~i_enable;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cur   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_act && i_enable) begin
                        r_state <= StPressWait;
                        r_cur   <= w_key;
                        r_cnt   <= '0;
                    end
                end
                StPressWait: begin
                    if (!w_same) begin
                        r_state <= StIdle;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= StHeld;
                    end else begin
                        r_cnt <= r_cnt + DBW'(1);
                    end
                end
                StHeld: begin
                    if (!w_same) begin
                        r_state <= StReleaseWait;
                        r_cnt   <= '0;
                    end
                end
                StReleaseWait: begin
                    if (w_same) begin
                        r_state <= StHeld;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + DBW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef HC148_KEY_REPEAT_EN
    localparam int unsigned RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);

    logic [RPW-1:0] r_rep;

    // Held at zero outside a stable HELD, so entry and bounce-return both restart the period.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep <= '0;
        end else if (r_state == StHeld && w_same && r_rep != REP_LAST) begin
            r_rep <= r_rep + RPW'(1);
        end else begin
            r_rep <= '0;
        end
    end

    assign w_rep_hit = (r_state == StHeld) && w_same && (r_rep == REP_LAST);
`else
    assign w_rep_hit = 1'b0;
`endif

    always_comb begin
        w_push = 1'b0;
        w_evt  = mk_evt(1'b0, r_cur);
        unique case (r_state)
            StPressWait: begin
                if (w_same && r_cnt == DB_LAST) begin
                    w_push = 1'b1;
                    w_evt  = mk_evt(1'b1, r_cur);
                end
            end
            StHeld: begin
                if (w_rep_hit) begin
                    w_push = 1'b1;
                    w_evt  = mk_evt(1'b1, r_cur);
                end
            end
            StReleaseWait: begin
                if (!w_same && r_cnt == DB_LAST) begin
                    w_push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    hc148_key_event_capture_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (evt_if.evt_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (o_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_if.evt_valid = ~w_empty;
    assign evt_if.evt_code  = w_empty ? '0 : w_head.code;
    assign evt_if.evt_press = ~w_empty & w_head.press;
    assign o_ei             = r_ei;
    assign o_overflow       = r_ovf;

endmodule

// File: tb/tb_hc148_key_event_capture.sv
// Directed self-checking bench for hc148_key_event_capture (DEBOUNCE 4, DEPTH 4, REPEAT 8).
module tb_hc148_key_event_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ei;
    logic [2:0] code_n;
    logic       gs_n;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    hc148_key_event_capture_if u_if ();

    hc148_key_event_capture #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .REPEAT_CYCLES   (8)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (enable),
        .o_ei       (ei),
        .i_code_n   (code_n),
        .i_gs_n     (gs_n),
        .evt_if     (u_if),
        .o_count    (count),
        .o_overflow (overflow),
        .i_ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_key(input logic [2:0] key);
        code_n = ~key;
        gs_n   = 1'b0;
    endtask

    task automatic drive_idle();
        code_n = 3'b111;
        gs_n   = 1'b1;
    endtask

    task automatic pop_expect(input string tag, input logic press, input logic [2:0] code);
        check({tag, "_valid"}, 32'(u_if.evt_valid), 32'(1));
        check({tag, "_press"}, 32'(u_if.evt_press), 32'(press));
        check({tag, "_code"}, 32'(u_if.evt_code), 32'(code));
        u_if.evt_ready = 1'b1;
        step(1);
        u_if.evt_ready = 1'b0;
    endtask

    task automatic press_release(input logic [2:0] key);
        drive_key(key);
        step(10);
        drive_idle();
        step(10);
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        ovf_clr        = 1'b0;
        u_if.evt_ready = 1'b0;
        drive_idle();

        // Reset
        step(2);
        check("rst_ei", 32'(ei), 32'(1));
        check("rst_valid", 32'(u_if.evt_valid), 32'(0));
        check("rst_code", 32'(u_if.evt_code), 32'(0));
        check("rst_press", 32'(u_if.evt_press), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        rst    = 1'b0;
        enable = 1'b1;
        step(1);
        check("ei_enabled", 32'(ei), 32'(0));

        // Clean press then release, seven-edge latency each way
        drive_key(3'd5);
        step(6);
        check("press_lat6", 32'(u_if.evt_valid), 32'(0));
        step(1);
        check("press_lat7", 32'(u_if.evt_valid), 32'(1));
        check("press_code", 32'(u_if.evt_code), 32'(5));
        check("press_kind", 32'(u_if.evt_press), 32'(1));
        check("press_count", 32'(count), 32'(1));
        step(13);
        u_if.evt_ready = 1'b1;
        drive_idle();
        step(6);
        check("rel_lat6", 32'(u_if.evt_valid), 32'(0));
        step(1);
        check("rel_lat7", 32'(u_if.evt_valid), 32'(1));
        check("rel_code", 32'(u_if.evt_code), 32'(5));
        check("rel_kind", 32'(u_if.evt_press), 32'(0));
        step(1);
        check("rel_popped", 32'(u_if.evt_valid), 32'(0));
        u_if.evt_ready = 1'b0;

        // Short press bounce and release glitch
        drive_key(3'd5);
        step(2);
        drive_idle();
        step(15);
        check("bounce_count", 32'(count), 32'(0));
        drive_key(3'd5);
        step(10);
        check("glitch_pre", 32'(count), 32'(1));
        drive_idle();
        step(2);
        drive_key(3'd5);
        step(15);
        check("glitch_count", 32'(count), 32'(1));
        drive_idle();
        step(10);
        check("glitch_rel", 32'(count), 32'(2));
        pop_expect("glitch_e0", 1'b1, 3'd5);
        pop_expect("glitch_e1", 1'b0, 3'd5);
        check("glitch_empty", 32'(count), 32'(0));

        // Overflow: six events into four entries
        press_release(3'd5);
        press_release(3'd2);
        press_release(3'd7);
        check("ovf_count", 32'(count), 32'(4));
        check("ovf_set", 32'(overflow), 32'(1));
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'(0));
        pop_expect("ovf_e0", 1'b1, 3'd5);
        pop_expect("ovf_e1", 1'b0, 3'd5);
        pop_expect("ovf_e2", 1'b1, 3'd2);
        pop_expect("ovf_e3", 1'b0, 3'd2);
        check("ovf_drained", 32'(count), 32'(0));

        // Code change while held: 5 -> 2
        drive_key(3'd5);
        step(10);
        drive_key(3'd2);
        step(20);
        check("chg_count", 32'(count), 32'(3));
        pop_expect("chg_e0", 1'b1, 3'd5);
        pop_expect("chg_e1", 1'b0, 3'd5);
        pop_expect("chg_e2", 1'b1, 3'd2);
        drive_idle();
        step(10);
        pop_expect("chg_e3", 1'b0, 3'd2);

        // Reset mid-debounce with queued events
        press_release(3'd3);
        check("mid_pre", 32'(count), 32'(2));
        drive_key(3'd4);
        step(4);
        rst = 1'b1;
        drive_idle();
        step(2);
        rst = 1'b0;
        check("mid_count", 32'(count), 32'(0));
        check("mid_valid", 32'(u_if.evt_valid), 32'(0));
        check("mid_ei", 32'(ei), 32'(1));
        step(20);
        check("mid_later", 32'(count), 32'(0));
        check("mid_ei_on", 32'(ei), 32'(0));

`ifdef HC148_KEY_REPEAT_EN
        drive_key(3'd3);
        step(7);
        check("rep_first", 32'(count), 32'(1));
        step(29);
        check("rep_count", 32'(count), 32'(4));
        drive_idle();
        pop_expect("rep_e0", 1'b1, 3'd3);
        pop_expect("rep_e1", 1'b1, 3'd3);
        pop_expect("rep_e2", 1'b1, 3'd3);
        pop_expect("rep_e3", 1'b1, 3'd3);
        step(10);
        pop_expect("rep_rel", 1'b0, 3'd3);
        check("rep_no_ovf", 32'(overflow), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
